// File: rtl/aes_feeder_pkg.sv
// Shared types and helpers for the AES block feeder.
// Holds the FSM state encoding, the sideband width default and the byte-lane
// helpers that turn a big-endian stream word into the aes_api byte order.
package aes_feeder_pkg;

  // Feeder control states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    ISSUE   = 2'd2,
    GAP     = 2'd3
  } state_e;

  localparam int          BYPASS_W_DEFAULT = 289;
  localparam int          WORDS_PER_BLOCK  = 4;
  localparam logic [15:0] MSG_BYTES_MAX    = 16'hFFFF;

  // Byte-reverse a stream word so that its earliest byte (word[31:24]) lands
  // in the lowest byte lane, then zero every lane past the valid byte count.
  // n_bytes == 0 means all four bytes are valid.
  function automatic logic [31:0] rev_mask_word(input logic [31:0] word,
                                                input logic [1:0]  n_bytes);
    logic [31:0] rev;
    rev = {word[7:0], word[15:8], word[23:16], word[31:24]};
    case (n_bytes)
      2'd1:    rev = rev & 32'h0000_00FF;
      2'd2:    rev = rev & 32'h0000_FFFF;
      2'd3:    rev = rev & 32'h00FF_FFFF;
      default: rev = rev;
    endcase
    return rev;
  endfunction

  // Number of message bytes carried by one accepted word.
  function automatic logic [2:0] word_bytes(input logic       last_word,
                                            input logic [1:0] n_bytes);
    logic [2:0] nb;
    if (last_word && (n_bytes != 2'd0)) nb = {1'b0, n_bytes};
    else                                nb = 3'd4;
    return nb;
  endfunction

  // Saturating add for the running message byte count.
  function automatic logic [15:0] sat_add16(input logic [15:0] acc,
                                            input logic [2:0]  inc);
    logic [16:0] sum;
    sum = {1'b0, acc} + {14'd0, inc};
    return sum[16] ? MSG_BYTES_MAX : sum[15:0];
  endfunction

endpackage

// File: rtl/aes_feeder.sv
// Purpose: packs a 32-bit byte stream into 128-bit aes_api blocks with a
//          captured sideband, last-block flag and total message byte count.
// Latency: o_new pulses 1 cycle after the block's final word is accepted.
// Backpressure: o_ready drops for ISSUE_GAP cycles starting at each o_new;
//          i_valid while o_ready=0 is ignored (no transfer).
//
// Ports:
//   clk, reset     single clock, synchronous active-high reset
//   i_word         stream word, i_word[31:24] is the earliest byte
//   i_valid        i_word valid; transfers when o_ready is also high
//   i_last_word    word is the final word of the message
//   i_bytes        valid bytes in the final word (0 means 4)
//   i_bypass_text  sideband, sampled with the first word of a message
//   o_ready        block accepts i_word this cycle
//   o_plain_text   byte-reversed, zero-filled block (stream byte j at [8j+7:8j])
//   o_new          one-cycle block strobe
//   o_last         set on the o_new of the message's final block
//   o_bypass_text  sideband of the message that owns the issued block
//   o_msg_bytes    saturating message byte count, valid while o_last=1
module aes_feeder
  import aes_feeder_pkg::*;
#(
  parameter int ISSUE_GAP = 2,
  parameter int BYPASS_W  = BYPASS_W_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         i_word,
  input  logic                i_valid,
  input  logic                i_last_word,
  input  logic [1:0]          i_bytes,
  input  logic [BYPASS_W-1:0] i_bypass_text,
  output logic                o_ready,
  output logic [127:0]        o_plain_text,
  output logic                o_new,
  output logic                o_last,
  output logic [BYPASS_W-1:0] o_bypass_text,
  output logic [15:0]         o_msg_bytes
);

  // GAP lasts ISSUE_GAP-1 cycles; the counter starts at 0 on GAP entry, so the
  // final GAP cycle is the one where the counter reads ISSUE_GAP-2. Unused
  // when ISSUE_GAP == 1 because GAP is skipped entirely.
  localparam logic [3:0] GAP_LAST = 4'(ISSUE_GAP - 2);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e              state_q, state_d;
  logic [1:0]          widx_q, widx_d;          // next word slot in the block
  logic [3:0]          gap_cnt_q, gap_cnt_d;
  logic [127:0]        asm_q, asm_d;            // block under assembly, output byte order
  logic [127:0]        plain_q, plain_d;        // issued block, held until the next issue
  logic [BYPASS_W-1:0] byp_stage_q, byp_stage_d; // sideband of the message in progress
  logic [BYPASS_W-1:0] byp_out_q, byp_out_d;     // sideband of the issued block
  logic [15:0]         msg_bytes_q, msg_bytes_d;
  logic                last_q, last_d;           // issued/pending block is the final one

  // ---------------------------------------------------------------------------
  // Transfer decode
  // ---------------------------------------------------------------------------
  logic                accept;
  logic                first_word;
  logic                blk_done;
  logic [31:0]         placed_word;
  logic [127:0]        asm_merged;
  logic [2:0]          word_nb;
  logic [BYPASS_W-1:0] byp_msg;

  always_comb begin
    accept      = i_valid && o_ready;
    first_word  = accept && (state_q == IDLE);
    // A block closes on its 4th word or on the message's last word. In IDLE
    // the slot index is always 0, so only i_last_word can close it there.
    blk_done    = accept && (i_last_word || (widx_q == 2'(WORDS_PER_BLOCK - 1)));

    // i_bytes only matters on the last word; earlier words are always full.
    placed_word = rev_mask_word(i_word, i_last_word ? i_bytes : 2'd0);
    word_nb     = word_bytes(i_last_word, i_bytes);

    // Unfilled slots of asm_q are already zero, so a plain slot write keeps
    // the zero-fill guarantee for short final blocks.
    asm_merged  = asm_q;
    asm_merged[{widx_q, 5'd0} +: 32] = placed_word;

    // A single-word message closes in IDLE, before the stage register has
    // taken the new sideband, so use the input directly in that case.
    byp_msg     = (state_q == IDLE) ? i_bypass_text : byp_stage_q;
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) state_d = i_last_word ? ISSUE : COLLECT;
      end
      COLLECT: begin
        if (blk_done) state_d = ISSUE;
      end
      ISSUE: begin
        if (ISSUE_GAP == 1) state_d = last_q ? IDLE : COLLECT;
        else                state_d = GAP;
      end
      GAP: begin
        if (gap_cnt_q == GAP_LAST) state_d = last_q ? IDLE : COLLECT;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs. Handshake and strobes are forced low while reset is held so
  // nothing transfers or issues in the reset cycle itself.
  // ---------------------------------------------------------------------------
  always_comb begin
    o_ready = 1'b0;
    o_new   = 1'b0;
    o_last  = 1'b0;
    if (!reset) begin
      case (state_q)
        IDLE, COLLECT: o_ready = 1'b1;
        ISSUE: begin
          o_new  = 1'b1;
          o_last = last_q;
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath next values
  // ---------------------------------------------------------------------------
  always_comb begin
    widx_d      = widx_q;
    gap_cnt_d   = 4'd0;
    asm_d       = asm_q;
    plain_d     = plain_q;
    byp_stage_d = byp_stage_q;
    byp_out_d   = byp_out_q;
    msg_bytes_d = msg_bytes_q;
    last_d      = last_q;

    if (state_q == GAP) gap_cnt_d = gap_cnt_q + 4'd1;

    if (first_word) begin
      byp_stage_d = i_bypass_text;
      msg_bytes_d = sat_add16(16'd0, word_nb);
    end else if (accept) begin
      msg_bytes_d = sat_add16(msg_bytes_q, word_nb);
    end

    if (blk_done) begin
      // Hand the completed block to the output registers and start the next
      // block from an all-zero assembly buffer.
      plain_d   = asm_merged;
      byp_out_d = byp_msg;
      last_d    = i_last_word;
      asm_d     = '0;
      widx_d    = 2'd0;
    end else if (accept) begin
      asm_d     = asm_merged;
      widx_d    = widx_q + 2'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      widx_q      <= 2'd0;
      gap_cnt_q   <= 4'd0;
      asm_q       <= '0;
      plain_q     <= '0;
      byp_stage_q <= '0;
      byp_out_q   <= '0;
      msg_bytes_q <= 16'd0;
      last_q      <= 1'b0;
    end else begin
      widx_q      <= widx_d;
      gap_cnt_q   <= gap_cnt_d;
      asm_q       <= asm_d;
      plain_q     <= plain_d;
      byp_stage_q <= byp_stage_d;
      byp_out_q   <= byp_out_d;
      msg_bytes_q <= msg_bytes_d;
      last_q      <= last_d;
    end
  end

  assign o_plain_text  = plain_q;
  assign o_bypass_text = byp_out_q;
  assign o_msg_bytes   = msg_bytes_q;

endmodule

// File: tb/tb_aes_feeder.sv
// Scoreboard bench for aes_feeder: a byte-level reference model pushes the
// expected blocks of each message, a negedge monitor pops and compares on
// every o_new and also checks issue latency and the post-issue ready gap.
module tb_aes_feeder;

  localparam int BW  = 289;
  localparam int GAP = 2;

  typedef struct {
    logic [127:0]  plain;
    logic          last;
    logic [BW-1:0] byp;
    logic [15:0]   nbytes;
  } exp_t;

  logic          clk;
  logic          reset;
  logic [31:0]   i_word;
  logic          i_valid;
  logic          i_last_word;
  logic [1:0]    i_bytes;
  logic [BW-1:0] i_bypass_text;
  logic          o_ready;
  logic [127:0]  o_plain_text;
  logic          o_new;
  logic          o_last;
  logic [BW-1:0] o_bypass_text;
  logic [15:0]   o_msg_bytes;

  aes_feeder #(.ISSUE_GAP(GAP), .BYPASS_W(BW)) dut (
    .clk           (clk),
    .reset         (reset),
    .i_word        (i_word),
    .i_valid       (i_valid),
    .i_last_word   (i_last_word),
    .i_bytes       (i_bytes),
    .i_bypass_text (i_bypass_text),
    .o_ready       (o_ready),
    .o_plain_text  (o_plain_text),
    .o_new         (o_new),
    .o_last        (o_last),
    .o_bypass_text (o_bypass_text),
    .o_msg_bytes   (o_msg_bytes)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  exp_t        expq[$];
  logic [31:0] msg_words[$];

  task automatic chk(input bit ok, input string nm,
                     input logic [319:0] act, input logic [319:0] req);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
  endtask

  function automatic logic [BW-1:0] rand_byp();
    logic [319:0] t;
    for (int i = 0; i < 10; i++) t[i*32 +: 32] = $urandom;
    return t[BW-1:0];
  endfunction

  // ---------------------------------------------------------------------------
  // Reference model: flatten the message into bytes, cut into 16-byte blocks.
  // ---------------------------------------------------------------------------
  task automatic push_msg(input logic [1:0] lb, input logic [BW-1:0] byp);
    logic [7:0] bytes[$];
    int n, nblk, nw, nb;
    exp_t e;
    nw = msg_words.size();
    for (int k = 0; k < nw; k++) begin
      nb = (k == nw - 1) ? ((lb == 2'd0) ? 4 : int'(lb)) : 4;
      for (int b = 0; b < nb; b++) bytes.push_back(msg_words[k][31 - 8*b -: 8]);
    end
    n    = bytes.size();
    nblk = (n + 15) / 16;
    for (int bi = 0; bi < nblk; bi++) begin
      e.plain = '0;
      for (int j = 0; j < 16; j++)
        if (16*bi + j < n) e.plain[8*j +: 8] = bytes[16*bi + j];
      e.last   = (bi == nblk - 1);
      e.byp    = byp;
      e.nbytes = (n > 65535) ? 16'hFFFF : 16'(n);
      expq.push_back(e);
    end
  endtask

  task automatic push_exp(input logic [127:0] plain, input logic last,
                          input logic [BW-1:0] byp, input logic [15:0] nbytes);
    exp_t e;
    e.plain = plain; e.last = last; e.byp = byp; e.nbytes = nbytes;
    expq.push_back(e);
  endtask

  // ---------------------------------------------------------------------------
  // Driver. Inputs change 1 time unit after posedge. While o_ready is low the
  // bus carries random junk with i_valid=1, which must never be captured.
  // ---------------------------------------------------------------------------
  task automatic drive_word(input logic [31:0] w, input logic last,
                            input logic [1:0] nb, input logic [BW-1:0] byp,
                            input bit rand_idle);
    bit done;
    int guard;
    done = 0; guard = 0;
    while (!done) begin
      @(posedge clk); #1;
      if (o_ready && (!rand_idle || $urandom_range(0, 3) != 0)) begin
        i_valid = 1'b1; i_word = w; i_last_word = last; i_bytes = nb;
        i_bypass_text = byp;
        done = 1;
      end else if (!o_ready) begin
        i_valid = 1'b1; i_word = $urandom; i_last_word = 1'($urandom);
        i_bytes = 2'($urandom); i_bypass_text = rand_byp();
      end else begin
        i_valid = 1'b0;
      end
      guard++;
      if (!done && guard > 64) begin
        chk(1'b0, "ready_timeout", 320'(guard), 320'(64));
        done = 1;
      end
    end
  endtask

  task automatic drive_msg(input logic [1:0] lb, input logic [BW-1:0] byp,
                           input bit rand_idle);
    int nw;
    nw = msg_words.size();
    for (int k = 0; k < nw; k++)
      drive_word(msg_words[k], k == nw - 1, (k == nw - 1) ? lb : 2'($urandom),
                 (k == 0) ? byp : rand_byp(), rand_idle);
  endtask

  task automatic go_idle();
    @(posedge clk); #1;
    i_valid = 1'b0;
  endtask

  task automatic rand_msg(input int nw, input logic [1:0] lb, input bit rand_idle);
    logic [BW-1:0] byp;
    byp = rand_byp();
    msg_words.delete();
    for (int k = 0; k < nw; k++) msg_words.push_back($urandom);
    push_msg(lb, byp);
    drive_msg(lb, byp, rand_idle);
    go_idle();
  endtask

  // Two-cycle reset; checks strobes inside the reset cycle and the cleared
  // registers once reset has been sampled.
  task automatic do_reset();
    @(posedge clk); #1;
    i_valid = 1'b0;
    reset   = 1'b1;
    #1;
    chk(o_ready == 1'b0, "rst_ready", 320'(o_ready), 320'(0));
    chk(o_new   == 1'b0, "rst_new",   320'(o_new),   320'(0));
    chk(o_last  == 1'b0, "rst_last",  320'(o_last),  320'(0));
    @(posedge clk); #1;
    chk(o_plain_text  == '0, "rst_plain", 320'(o_plain_text),  320'(0));
    chk(o_bypass_text == '0, "rst_byp",   320'(o_bypass_text), 320'(0));
    chk(o_msg_bytes   == '0, "rst_bytes", 320'(o_msg_bytes),   320'(0));
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  initial begin
    bit   prev_final;
    int   wib;
    int   since_new;
    exp_t e;
    prev_final = 0; wib = 0; since_new = 99;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_final = 0; wib = 0; since_new = 99;
      end else begin
        if (o_new || prev_final)
          chk(o_new == prev_final, "new_latency", 320'(o_new), 320'(prev_final));
        if (o_new) begin
          since_new = 0;
          if (expq.size() == 0) begin
            chk(1'b0, "unexpected_new", 320'(o_plain_text), 320'(0));
          end else begin
            e = expq.pop_front();
            chk(o_plain_text == e.plain, "plain_text", 320'(o_plain_text), 320'(e.plain));
            chk(o_last == e.last, "last", 320'(o_last), 320'(e.last));
            chk(o_bypass_text == e.byp, "bypass_text", 320'(o_bypass_text), 320'(e.byp));
            if (e.last)
              chk(o_msg_bytes == e.nbytes, "msg_bytes", 320'(o_msg_bytes), 320'(e.nbytes));
          end
        end else if (since_new < 99) begin
          since_new++;
        end
        if (since_new < GAP)
          chk(o_ready == 1'b0, "gap_ready_low", 320'(o_ready), 320'(0));
        else if (since_new == GAP)
          chk(o_ready == 1'b1, "ready_after_gap", 320'(o_ready), 320'(1));
        if (o_last && !o_new)
          chk(1'b0, "stray_last", 320'(o_last), 320'(0));
        prev_final = 0;
        if (i_valid && o_ready) begin
          if (i_last_word || wib == 3) begin
            prev_final = 1; wib = 0;
          end else begin
            wib++;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [BW-1:0] byp;
    int guard;

    reset = 1'b1; i_valid = 1'b0; i_word = '0; i_last_word = 1'b0;
    i_bytes = '0; i_bypass_text = '0;
    do_reset();

    // Known-answer full block, words back to back.
    byp = rand_byp();
    push_exp(128'h9A26F5AFC50959A5E50684F8253231D9, 1'b1, byp, 16'd16);
    msg_words = '{32'hD9313225, 32'hF88406E5, 32'hA55909C5, 32'hAFF5269A};
    drive_msg(2'd0, byp, 1'b0);
    go_idle();

    // Known-answer single partial word.
    byp = rand_byp();
    push_exp(128'h000000000000000000000000000031D9, 1'b1, byp, 16'd2);
    msg_words = '{32'hD9313225};
    drive_msg(2'd2, byp, 1'b0);
    go_idle();

    // 12-word continuous stream: three blocks, last only on the third.
    rand_msg(12, 2'd0, 1'b0);

    // Reset after two words of an unfinished message: nothing may issue.
    repeat (3) go_idle();
    drive_word($urandom, 1'b0, 2'd0, rand_byp(), 1'b0);
    drive_word($urandom, 1'b0, 2'd0, rand_byp(), 1'b0);
    do_reset();
    rand_msg(4, 2'd0, 1'b0);

    // Block-boundary cases: exactly 16n bytes, and one byte past it.
    rand_msg(8, 2'd0, 1'b1);
    rand_msg(9, 2'd1, 1'b1);
    rand_msg(4, 2'd3, 1'b1);

    // Random messages with random idle cycles.
    for (int m = 0; m < 30; m++)
      rand_msg($urandom_range(1, 20), 2'($urandom), 1'b1);

    // Byte-count saturation: 65600 bytes reports 16'hFFFF.
    rand_msg(16400, 2'd0, 1'b0);

    guard = 0;
    while (expq.size() != 0 && guard < 500) begin
      @(posedge clk);
      guard++;
    end
    repeat (10) @(posedge clk);
    chk(expq.size() == 0, "queue_drained", 320'(expq.size()), 320'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/aes_feeder.md
AES_FEEDER -- requirements
Module: aes_feeder

Interface
REQ-001 The module SHALL have parameter ISSUE_GAP, default 2, giving the minimum cycles from one o_new pulse to the next o_ready (allowed range 1..15).
REQ-002 The module SHALL have parameter BYPASS_W, default 289, giving the width of the bypass-text sideband.
REQ-003 clk  input  1  single clock; all logic on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 i_word  input  32  stream word; i_word[31:24] is the earliest byte.
REQ-006 i_valid  input  1  i_word is valid.
REQ-007 i_last_word  input  1  the word is the final word of the message.
REQ-008 i_bytes  input  2  valid bytes in the final word; 0 means 4; ignored unless i_last_word=1.
REQ-009 i_bypass_text  input  BYPASS_W  sideband, sampled with the first word of a message.
REQ-010 o_ready  output  1  the block accepts i_word this cycle.
REQ-011 o_plain_text  output  128  byte-reversed block for aes_api i_plain_text.
REQ-012 o_new  output  1  one-cycle block strobe for aes_api i_new.
REQ-013 o_last  output  1  the block is the final block of the message; drives aes_api i_last.
REQ-014 o_bypass_text  output  BYPASS_W  captured sideband for aes_api i_bypass_text.
REQ-015 o_msg_bytes  output  16  total message byte count; valid while o_last=1.

Function
REQ-016 A word SHALL transfer only on a cycle with i_valid=1 and o_ready=1; i_valid while o_ready=0 is ignored.
REQ-017 State machine states SHALL be IDLE, COLLECT, ISSUE and GAP.
REQ-018 IDLE SHALL assert o_ready; the first accepted word SHALL capture i_bypass_text, clear the byte count and enter COLLECT.
REQ-019 COLLECT SHALL assert o_ready and pack words in arrival order: word k occupies stream bytes 4k..4k+3.
REQ-020 Accepting the 4th word, or any word with i_last_word=1, SHALL enter ISSUE on the next cycle, with o_ready low from that cycle.
REQ-021 Stream byte j (0..15) SHALL appear at o_plain_text[8j+7:8j]; unfilled bytes, including bytes beyond i_bytes in the final word, SHALL be zero.
REQ-022 Latency: o_new SHALL assert exactly 1 cycle after the accepting edge of the block's final word, for one cycle, in ISSUE.
REQ-023 o_last SHALL equal 1 only during the o_new cycle of the block that contains the last word.
REQ-024 o_plain_text and o_bypass_text SHALL hold stable from o_new until the next block is issued.
REQ-025 After ISSUE, the block SHALL stay in GAP for ISSUE_GAP-1 cycles with o_ready=0 (ISSUE_GAP=1 skips GAP), then go to COLLECT, or to IDLE if o_last was issued.
REQ-026 o_msg_bytes SHALL add 4 per word, or i_bytes (0 counted as 4) on the last word, and SHALL saturate at 16'hFFFF.
REQ-027 Boundary cases:
- A message of exactly 16n bytes SHALL issue n blocks and no empty trailing block.
- i_last_word on the first word SHALL give a single block with o_last=1.

Reset
REQ-028 Reset SHALL force IDLE, zero the word index, o_plain_text, o_bypass_text and o_msg_bytes, and drive o_new=0, o_last=0 and o_ready=0 during the reset cycle.
REQ-029 Reset mid-message SHALL discard partial data with no o_new; the next accepted word SHALL start a new message.

Structure
REQ-030 A shared package aes_feeder_pkg SHALL hold the state enum (IDLE, COLLECT, ISSUE, GAP), the BYPASS_W default and a function for byte reversal plus zero-masking.
REQ-031 The block SHALL be a single module with no sub-modules; its outputs SHALL connect port-for-port to aes_api inputs.

Verification
REQ-032 Words D9313225, F88406E5, A55909C5, AFF5269A at cycles 0-3 with last on word 3 -> o_new at cycle 4, o_plain_text=9A26F5AFC50959A5E50684F8253231D9, o_last=1, o_msg_bytes=16.
REQ-033 Single word D9313225 with i_last_word=1 and i_bytes=2 -> o_plain_text=000000000000000000000000000031D9, o_last=1, o_msg_bytes=2.
REQ-034 Continuous 12-word stream with ISSUE_GAP=2 and i_valid held high -> o_new at cycles 4, 10, 16; o_ready low at 4-5 and 10-11; o_last only at cycle 16; o_msg_bytes=48.
REQ-035 i_bypass_text changed after the first word -> o_bypass_text keeps the first-word value for all 3 blocks.
REQ-036 Reset asserted after 2 words -> no o_new and all outputs zero; a following 4-word message issues correctly at the 4th word plus 1 cycle.
REQ-037 i_valid=1 with o_ready=0 in GAP, carrying a different word -> word not captured and no change in o_msg_bytes.
